// File: rtl/ps2_pkg.sv
// Shared types and defaults for the PS/2 host controller.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_BITS,
        RX_CHECK,
        TX_INHIBIT,
        TX_RTS,
        TX_BITS,
        TX_ACK,
        TX_END
    } ps2_state_e;

    localparam int FRAME_BITS            = 11;
    localparam int DEF_FILTER_LEN        = 8;
    localparam int DEF_INHIBIT_CYCLES    = 10000;
    localparam int DEF_DATA_SETUP_CYCLES = 2000;
    localparam int DEF_TIMEOUT_CYCLES    = 200000;

    // Parity bit that makes data plus parity contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus consecutive-sample glitch filter for one PS/2 line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the accepted level.
    always_comb begin
        sync_d  = {sync_q[0], line_in};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) level_d = sync_q[1];
            else                                 cnt_d   = cnt_q + CNT_W'(1);
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_interface.sv
// Bidirectional PS/2 host: receives device bytes and sends host commands
// over open-drain ps2_clk / ps2_data.
module ps2_host_interface
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN        = DEF_FILTER_LEN,
    parameter int INHIBIT_CYCLES    = DEF_INHIBIT_CYCLES,
    parameter int DATA_SETUP_CYCLES = DEF_DATA_SETUP_CYCLES,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    input  logic [7:0] tx_data,
    input  logic       write_data,
    output logic [7:0] rx_data,
    output logic       read_data,
    output logic       busy,
    output logic       tx_done,
    output logic       err
);

    localparam int CW    = $clog2(TIMEOUT_CYCLES + INHIBIT_CYCLES + DATA_SETUP_CYCLES + 1);
    localparam int NBITS = FRAME_BITS - 1;

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    sreg_q, sreg_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          read_data_q, read_data_d;
    logic          tx_done_q, tx_done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          clk_f, clk_fall, data_f, data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_clk),
        .level   (clk_f),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_data),
        .level   (data_f),
        .fall    (data_fall_unused)
    );

    assign ps2_clk  = clk_oe_q  ? 1'b0 : 1'bz;
    assign ps2_data = data_oe_q ? 1'b0 : 1'bz;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sreg_d      = sreg_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        rx_data_d   = rx_data_q;
        read_data_d = 1'b0;
        tx_done_d   = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (write_data) begin
                    sreg_d   = {1'b1, odd_parity(tx_data), tx_data};
                    clk_oe_d = 1'b1;
                    state_d  = TX_INHIBIT;
                end else if (clk_fall && !data_f) begin
                    state_d = RX_BITS;
                end
            end
            // Shift in from the top so d0 lands in bit 0 after ten edges.
            RX_BITS: if (clk_fall) begin
                sreg_d    = {data_f, sreg_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'(NBITS - 1)) state_d = RX_CHECK;
            end
            RX_CHECK: begin
                if (sreg_q[9] && (^sreg_q[8:0])) begin
                    rx_data_d   = sreg_q[7:0];
                    read_data_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            TX_INHIBIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = TX_RTS;
                end
            end
            TX_RTS: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_SETUP_CYCLES - 1)) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = TX_BITS;
                end
            end
            TX_BITS: if (clk_fall) begin
                data_oe_d = ~sreg_q[0];
                sreg_d    = {1'b1, sreg_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'(NBITS - 1)) state_d = TX_ACK;
            end
            TX_ACK: if (clk_fall) begin
                if (!data_f) tx_done_d = 1'b1;
                else         err_d     = 1'b1;
                state_d = TX_END;
            end
            TX_END: if (clk_f && data_f) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Inter-edge watchdog; a device that stalls mid-frame frees the bus.
        if (state_q inside {RX_BITS, TX_BITS, TX_ACK, TX_END}) begin
            if (clk_fall) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                err_d     = 1'b1;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                cnt_d     = '0;
                state_d   = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            sreg_q      <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            rx_data_q   <= '0;
            read_data_q <= 1'b0;
            tx_done_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sreg_q      <= sreg_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            rx_data_q   <= rx_data_d;
            read_data_q <= read_data_d;
            tx_done_q   <= tx_done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign read_data = read_data_q;
    assign tx_done   = tx_done_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ps2_host_interface.sv
// Directed bench: a PS/2 device model on pulled-up lines exercises receive,
// transmit, glitch rejection, timeout and reset abort with shortened timings.
module tb_ps2_host_interface;

    localparam int HALF  = 60;
    localparam int INH   = 200;
    localparam int SETUP = 50;
    localparam int TMO   = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       write_data = 1'b0;
    logic [7:0] rx_data;
    logic       read_data, busy, tx_done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    wire        ps2_clk, ps2_data;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rd = 0, n_done = 0, n_err = 0, n_overlap = 0;

    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    always #5 clk = ~clk;

    ps2_host_interface #(
        .FILTER_LEN        (8),
        .INHIBIT_CYCLES    (INH),
        .DATA_SETUP_CYCLES (SETUP),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .tx_data    (tx_data),
        .write_data (write_data),
        .rx_data    (rx_data),
        .read_data  (read_data),
        .busy       (busy),
        .tx_done    (tx_done),
        .err        (err)
    );

    always @(negedge clk) begin
        if (read_data === 1'b1) n_rd++;
        if (tx_done === 1'b1)   n_done++;
        if (err === 1'b1)       n_err++;
        if ((read_data === 1'b1) + (tx_done === 1'b1) + (err === 1'b1) > 1) n_overlap++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dev_bit(input logic b);
        dev_data_low = ~b;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
    endtask

    // Sends the first nbits of {stop, parity, data, start}; no trailing gap.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int nbits);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) dev_bit(bits[i]);
        dev_data_low = 1'b0;
    endtask

    task automatic dev_clock_host(input logic ack, output logic [9:0] got);
        got = '0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            got[i] = ps2_data;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = ack;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_write(input logic [7:0] d);
        @(posedge clk); #1;
        tx_data    = d;
        write_data = 1'b1;
        @(posedge clk); #1;
        write_data = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            if (busy === 1'b0) break;
        end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        int rd0, dn0, er0, k;
        logic [9:0] got;
        logic       glitch_busy;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_read", read_data, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_tx_done", tx_done, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_clk_line", ps2_clk, 1'b1);
        chk("reset_data_line", ps2_data, 1'b1);
        rst = 1'b0;
        gap(20);

        // Receive 0x1C; stop bit driven by hand to time read_data latency
        rd0 = n_rd; er0 = n_err;
        send_frame(8'h1C, 1'b0, 1'b1, 10);
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (read_data === 1'b1) break;
        end
        chk("rx_latency", k, 12);
        @(negedge clk);
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        gap(40);
        chk("rx_1c_data", rx_data, 8'h1C);
        chk("rx_1c_reads", n_rd - rd0, 1);
        chk("rx_1c_errs", n_err - er0, 0);
        chk("rx_1c_busy", busy, 1'b0);

        // Parity error on 0x1C
        rd0 = n_rd; er0 = n_err;
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        gap(40);
        chk("par_errs", n_err - er0, 1);
        chk("par_reads", n_rd - rd0, 0);
        chk("par_rx_hold", rx_data, 8'h1C);

        // Framing error: 0x33 with correct parity but stop bit 0
        rd0 = n_rd; er0 = n_err;
        send_frame(8'h33, 1'b1, 1'b0, 11);
        gap(40);
        chk("frame_errs", n_err - er0, 1);
        chk("frame_reads", n_rd - rd0, 0);
        chk("frame_rx_hold", rx_data, 8'h1C);

        // 3-cycle glitch on ps2_clk while idle, data low to tempt a start
        dev_data_low = 1'b1;
        @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        glitch_busy = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) glitch_busy = 1'b1;
        end
        dev_data_low = 1'b0;
        chk("glitch_busy", glitch_busy, 1'b0);
        gap(20);

        // Transmit 0xFF with acknowledge; a second write during inhibit is dropped
        dn0 = n_done; er0 = n_err;
        start_write(8'hFF);
        chk("tx_busy", busy, 1'b1);
        chk("tx_inhibit_clk", ps2_clk, 1'b0);
        tx_data    = 8'h00;
        write_data = 1'b1;
        @(posedge clk); #1;
        write_data = 1'b0;
        repeat (198) @(posedge clk);
        #1;
        chk("tx_inhibit_end_data", ps2_data, 1'b1);
        chk("tx_inhibit_end_clk", ps2_clk, 1'b0);
        @(posedge clk); #1;
        chk("tx_rts_data", ps2_data, 1'b0);
        repeat (49) @(posedge clk);
        #1;
        chk("tx_rts_clk_held", ps2_clk, 1'b0);
        @(posedge clk); #1;
        chk("tx_clk_released", ps2_clk, 1'b1);
        dev_clock_host(1'b1, got);
        chk("tx_ff_bits", got, 10'h3FF);
        wait_idle("tx_ff_idle");
        chk("tx_ff_done", n_done - dn0, 1);
        chk("tx_ff_errs", n_err - er0, 0);
        gap(20);

        // Transmit 0x96 with no acknowledge
        dn0 = n_done; er0 = n_err;
        start_write(8'h96);
        repeat (INH + SETUP) @(posedge clk);
        #1;
        chk("tx_96_clk_released", ps2_clk, 1'b1);
        dev_clock_host(1'b0, got);
        chk("tx_96_bits", got, 10'h396);
        wait_idle("tx_96_idle");
        chk("tx_96_done", n_done - dn0, 0);
        chk("tx_96_errs", n_err - er0, 1);
        gap(20);

        // Timeout: device stops after 4 bits
        er0 = n_err;
        send_frame(8'h5A, 1'b1, 1'b1, 4);
        chk("tmo_busy", busy, 1'b1);
        for (k = 1; k <= TMO + 200; k++) begin
            @(posedge clk); #1;
            if (err === 1'b1) break;
        end
        chk("tmo_cycles", k, TMO - HALF + 11);
        chk("tmo_busy_clear", busy, 1'b0);
        gap(20);
        chk("tmo_errs", n_err - er0, 1);

        // Valid 0x5A after timeout
        rd0 = n_rd;
        send_frame(8'h5A, 1'b1, 1'b1, 11);
        gap(40);
        chk("rx_5a_data", rx_data, 8'h5A);
        chk("rx_5a_reads", n_rd - rd0, 1);

        // Reset during TX_BITS of 0x55 while host drives d1=0
        dn0 = n_done;
        start_write(8'h55);
        repeat (INH + SETUP) @(posedge clk);
        repeat (HALF) @(negedge clk);
        repeat (2) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        chk("rst_pre_data_low", ps2_data, 1'b0);
        chk("rst_pre_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_data_released", ps2_data, 1'b1);
        chk("rst_clk_released", ps2_clk, 1'b1);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        gap(50);
        chk("rst_no_done", n_done - dn0, 0);
        chk("no_overlap", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_interface.md
Name: ps2_host_interface

Overview:
- Bidirectional PS/2 host controller for keyboard/mouse on open-drain ps2_clk/ps2_data lines.
- Receives device frames and presents each byte with a one-cycle strobe.
- Transmits host-to-device command bytes using the standard inhibit/request-to-send protocol.
- Sits between the board PS/2 pins and the VGA/game logic; runs on the 100 MHz system clock.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before a line change is accepted.
- INHIBIT_CYCLES, 10000: clk cycles ps2_clk is held low to start a transmit (100 us at 100 MHz).
- DATA_SETUP_CYCLES, 2000: clk cycles ps2_data is held low before ps2_clk is released (20 us).
- TIMEOUT_CYCLES, 200000: maximum clk cycles between filtered ps2_clk falling edges inside a frame (2 ms).

Ports:
- clk, input, 1: system clock, 100 MHz, rising edge.
- rst, input, 1: synchronous active-high reset.
- ps2_clk, inout, 1: PS/2 clock; open-drain, driven 0 or high-Z only.
- ps2_data, inout, 1: PS/2 data; open-drain, driven 0 or high-Z only.
- tx_data, input, 8: byte to transmit; sampled when write_data is accepted.
- write_data, input, 1: transmit request; accepted only when busy=0.
- rx_data, output, 8: last received byte; held until the next valid frame.
- read_data, output, 1: one-cycle pulse when rx_data is updated.
- busy, output, 1: high while a frame is in progress in either direction.
- tx_done, output, 1: one-cycle pulse when the device acknowledges a transmitted byte.
- err, output, 1: one-cycle pulse on parity error, framing error, missing acknowledge or timeout.

Behaviour:
- Reset:
  - Both lines released (high-Z).
  - rx_data=0; read_data, tx_done, err and busy = 0.
  - FSM returns to IDLE and all counters clear.
  - Reset asserted mid-frame aborts the frame; lines are released on the cycle after the reset edge.
- Line conditioning:
  - Each line passes through a 2-FF synchronizer, then the FILTER_LEN glitch filter.
  - A falling edge is a filtered 1->0 transition of ps2_clk.
- Frame format: 11 bits.
  - Start bit 0.
  - Data bits d0..d7, LSB first.
  - Odd parity bit (count of ones over data plus parity is odd).
  - Stop bit 1.
- FSM states: IDLE, RX_BITS, RX_CHECK, TX_INHIBIT, TX_RTS, TX_BITS, TX_ACK, TX_END.
- IDLE:
  - A falling edge with filtered data=0 enters RX_BITS.
  - A falling edge with data=1 is ignored.
  - An accepted write_data latches tx_data and enters TX_INHIBIT.
  - If both occur in the same cycle, transmit wins.
- RX_BITS:
  - Samples filtered data on each falling edge until 10 bits after the start bit have been collected, then enters RX_CHECK.
- RX_CHECK:
  - If parity and stop are correct: rx_data updates and read_data pulses in the same cycle.
  - Otherwise err pulses and rx_data is unchanged.
  - Then returns to IDLE.
  - Latency from the stop-bit falling edge to read_data: at most 2 clk cycles after the filtered edge.
- TX_INHIBIT: drives ps2_clk low for INHIBIT_CYCLES.
- TX_RTS: drives ps2_data low (start bit), holds for DATA_SETUP_CYCLES, then releases ps2_clk.
- TX_BITS:
  - On each device falling edge, drives the next bit in order d0..d7, parity, stop.
  - Bit 1 means release the line (high-Z); bit 0 means drive low.
  - After the stop bit, ps2_data stays released.
- TX_ACK:
  - On the next falling edge, sampled data=0 means acknowledge: tx_done pulses.
  - Sampled data=1 means err pulses.
- TX_END: waits for both filtered lines high, then goes to IDLE.
- busy=1 in every state except IDLE.
- Timeout: in any non-IDLE state other than TX_INHIBIT and TX_RTS, if TIMEOUT_CYCLES elapse with no falling edge:
  - err pulses;
  - both lines are released;
  - the FSM goes to IDLE.
- write_data while busy=1 is ignored (not queued).
- read_data, tx_done and err are never asserted in the same cycle.

Decomposition:
- Package ps2_pkg: FSM state enum, frame-length constant (11), and default cycle constants.
- One sub-module: ps2_line_filter, holding the synchronizer, glitch filter and falling-edge detect.
  - Instantiated twice, once per line.
  - The edge output is used only for the clock instance.

Test Plan:
- Receive: device model sends 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 10 kHz.
  - read_data pulses exactly once; rx_data=0x1C; err stays 0.
- Parity error: send 0x1C with parity bit 1.
  - err pulses once; no read_data; rx_data keeps its previous value.
- Glitch: 3-cycle low pulse on ps2_clk while IDLE.
  - No state change; busy stays 0.
- Transmit: write_data with tx_data=0xFF.
  - ps2_clk low for 10000 cycles, then ps2_data low.
  - Device clocks out bits 1×8, parity 1, stop 1, then acknowledges.
  - tx_done pulses once; busy returns to 0.
- Timeout: device stops after 4 bits.
  - After 200000 cycles err pulses and FSM returns to IDLE.
  - A following valid frame 0x5A yields rx_data=0x5A.
- Reset mid-transmit: assert rst during TX_BITS.
  - Both lines released the next cycle; busy=0; no tx_done.
